// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the MUL/DIV bus sequencer: state encoding,
// ALU op codes, latency counter width and the op-to-ALU-code mapping.
package muldiv_sequencer_pkg;

  // 3-bit binary state encoding shared with the main control FSM
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Y = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WR_LO  = 3'd3,
    ST_WR_HI  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // ALU op codes presented on alu_op
  localparam logic [1:0] ALU_NOP = 2'd0;
  localparam logic [1:0] ALU_MUL = 2'd1;
  localparam logic [1:0] ALU_DIV = 2'd2;

  // Encoding of the op request input
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Latency counter width; latencies are limited to 1..63
  localparam int CNT_BITS = 6;

  // Map the latched op bit onto the ALU op code driven during EXEC
  function automatic logic [1:0] alu_code(input logic op_bit);
    logic [1:0] code;
    if (op_bit == OP_DIV) begin
      code = ALU_DIV;
    end else begin
      code = ALU_MUL;
    end
    return code;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_reg_sel_decoder.sv
// Index-to-one-hot decoder with enable; selects which GP register drives
// the shared bus. All-zero output when disabled.
module muldiv_sequencer_reg_sel_decoder #(
  parameter int IDX_BITS = 4
) (
  input  logic                       en,
  input  logic [IDX_BITS-1:0]        idx,
  output logic [(1<<IDX_BITS)-1:0]   onehot
);

  localparam int OUT_W = 1 << IDX_BITS;

  // Decode the register index into a single asserted select line
  always_comb begin
    onehot = {OUT_W{1'b0}};
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MUL/DIV sequencer: moves Ra into Y, presents Rb with the ALU op until the
// ALU latency has elapsed, then copies Zlow to LO and Zhigh to HI over the
// shared bus. Outputs are registered and derived from the next state and
// next latched fields, so each output is a clean function of the state the
// machine is in during that cycle.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 32,
  parameter int REG_BITS = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic                       op,
  input  logic [REG_BITS-1:0]        ra,
  input  logic [REG_BITS-1:0]        rb,
  output logic [(1<<REG_BITS)-1:0]   Rout,
  output logic                       Yin,
  output logic                       Zin,
  output logic [1:0]                 alu_op,
  output logic                       ZLowOut,
  output logic                       ZHighOut,
  output logic                       LOin,
  output logic                       HIin,
  output logic                       busy,
  output logic                       done
);

  localparam int NREG = 1 << REG_BITS;

  // Latencies must fit the 6-bit counter and be at least one cycle
  if (MUL_LAT < 1 || MUL_LAT > 63) begin : g_mul_lat_bad
    $error("MUL_LAT out of range 1..63");
  end
  if (DIV_LAT < 1 || DIV_LAT > 63) begin : g_div_lat_bad
    $error("DIV_LAT out of range 1..63");
  end

  localparam logic [CNT_BITS-1:0] MUL_LOAD = CNT_BITS'(MUL_LAT - 1);
  localparam logic [CNT_BITS-1:0] DIV_LOAD = CNT_BITS'(DIV_LAT - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_nxt;
  logic                  lat_op;
  logic                  lat_op_nxt;
  logic [REG_BITS-1:0]   lat_ra;
  logic [REG_BITS-1:0]   lat_ra_nxt;
  logic [REG_BITS-1:0]   lat_rb;
  logic [REG_BITS-1:0]   lat_rb_nxt;

  logic                  sel_en;
  logic [REG_BITS-1:0]   sel_idx;
  logic [NREG-1:0]       sel_onehot;

  // Next-state, counter and operand-latch logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lat_op_nxt = lat_op;
    lat_ra_nxt = lat_ra;
    lat_rb_nxt = lat_rb;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lat_op_nxt = op;
          lat_ra_nxt = ra;
          lat_rb_nxt = rb;
          state_nxt  = ST_LOAD_Y;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_LOAD_Y: begin
        if (lat_op == OP_DIV) begin
          cnt_nxt = DIV_LOAD;
        end else begin
          cnt_nxt = MUL_LOAD;
        end
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt != {CNT_BITS{1'b0}}) begin
          cnt_nxt   = cnt - CNT_BITS'(1);
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        state_nxt = ST_WR_HI;
      end
      ST_WR_HI: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A start here chains straight into the next op with no idle cycle
        if (start) begin
          lat_op_nxt = op;
          lat_ra_nxt = ra;
          lat_rb_nxt = rb;
          state_nxt  = ST_LOAD_Y;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus register select: Ra while loading Y, Rb while the ALU executes
  always_comb begin
    sel_en  = 1'b0;
    sel_idx = lat_rb_nxt;
    if (state_nxt == ST_LOAD_Y) begin
      sel_en  = 1'b1;
      sel_idx = lat_ra_nxt;
    end else if (state_nxt == ST_EXEC) begin
      sel_en  = 1'b1;
      sel_idx = lat_rb_nxt;
    end else begin
      sel_en  = 1'b0;
      sel_idx = lat_rb_nxt;
    end
  end

  muldiv_sequencer_reg_sel_decoder #(
    .IDX_BITS (REG_BITS)
  ) reg_sel_decoder (
    .en     (sel_en),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  // State, counter, latched operands and registered strobe outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      cnt      <= {CNT_BITS{1'b0}};
      lat_op   <= 1'b0;
      lat_ra   <= {REG_BITS{1'b0}};
      lat_rb   <= {REG_BITS{1'b0}};
      Rout     <= {NREG{1'b0}};
      Yin      <= 1'b0;
      Zin      <= 1'b0;
      alu_op   <= ALU_NOP;
      ZLowOut  <= 1'b0;
      ZHighOut <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_op   <= lat_op_nxt;
      lat_ra   <= lat_ra_nxt;
      lat_rb   <= lat_rb_nxt;
      Rout     <= sel_onehot;
      Yin      <= (state_nxt == ST_LOAD_Y);
      Zin      <= (state_nxt == ST_EXEC) && (cnt_nxt == {CNT_BITS{1'b0}});
      alu_op   <= (state_nxt == ST_EXEC) ? alu_code(lat_op_nxt) : ALU_NOP;
      ZLowOut  <= (state_nxt == ST_WR_LO);
      ZHighOut <= (state_nxt == ST_WR_HI);
      LOin     <= (state_nxt == ST_WR_LO);
      HIin     <= (state_nxt == ST_WR_HI);
      busy     <= (state_nxt == ST_LOAD_Y) || (state_nxt == ST_EXEC) ||
                  (state_nxt == ST_WR_LO)  || (state_nxt == ST_WR_HI);
      done     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. Each accepted start expands into
// the per-cycle output trace it should produce; a negedge monitor pops and
// compares one entry per cycle. A small reg32/Y/Z/LO/HI model on the bus
// checks the arithmetic results of directed operations.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [15:0] Rout;
  logic        Yin, Zin, ZLowOut, ZHighOut, LOin, HIin, busy, done;
  logic [1:0]  alu_op;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MUL_LAT(1), .DIV_LAT(32), .REG_BITS(4)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb),
    .Rout(Rout), .Yin(Yin), .Zin(Zin), .alu_op(alu_op),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [15:0] rout;
    logic        yin;
    logic        zin;
    logic [1:0]  alu;
    logic        zlo;
    logic        zhi;
    logic        loin;
    logic        hiin;
    logic        busy;
    logic        done;
  } outs_t;

  outs_t exp_q[$];
  int vectors  = 0;
  int fails    = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  // Datapath model: register file, Y, Z, LO, HI on the shared bus
  logic [31:0] regs [16];
  logic [31:0] y_reg, lo_reg, hi_reg, bus;
  logic [63:0] z_reg;

  always_comb begin
    bus = 32'd0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = regs[i];
    if (ZLowOut)  bus = z_reg[31:0];
    if (ZHighOut) bus = z_reg[63:32];
  end

  always @(posedge clk) begin
    if (Yin) y_reg <= bus;
    if (Zin && alu_op == 2'd1) z_reg <= {32'd0, y_reg} * {32'd0, bus};
    if (Zin && alu_op == 2'd2 && bus != 32'd0) z_reg <= {y_reg % bus, y_reg / bus};
    if (LOin) lo_reg <= bus;
    if (HIin) hi_reg <= bus;
  end

  // Expand one accepted op into its expected cycle-by-cycle outputs
  function automatic void push_txn(input logic o, input logic [3:0] a, input logic [3:0] b);
    outs_t e;
    int lat;
    logic [15:0] one;
    one = 16'd1;
    lat = o ? 32 : 1;
    e = '0; e.rout = one << a; e.yin = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
    for (int i = 0; i < lat; i++) begin
      e = '0; e.rout = one << b; e.alu = o ? 2'd2 : 2'd1;
      e.zin = (i == lat - 1); e.busy = 1'b1; exp_q.push_back(e);
    end
    e = '0; e.zlo = 1'b1; e.loin = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
    e = '0; e.zhi = 1'b1; e.hiin = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
    e = '0; e.done = 1'b1; exp_q.push_back(e);
  endfunction

  // Scoreboard monitor: compare outputs each cycle and register accepted starts
  always @(negedge clk) begin : monitor
    outs_t act;
    outs_t exp_v;
    if (clr) exp_q.delete();
    act = {Rout, Yin, Zin, alu_op, ZLowOut, ZHighOut, LOin, HIin, busy, done};
    exp_v = '0;
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    vectors++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, exp_v);
    end
    vectors++;
    if ($countones({Rout, ZLowOut, ZHighOut}) > 1) begin
      fails++;
      $display("FAIL bus_onehot t=%0t actual=%b required=at most one driver", $time,
               {Rout, ZLowOut, ZHighOut});
    end
    if (done === 1'b1) done_cnt++;
    if (!clr && start === 1'b1 && exp_q.size() == 0) begin
      push_txn(op, ra, rb);
      acc_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; op = 1'b0; ra = 4'd0; rb = 4'd0;
    #1;
    vectors++;
    if ({Rout, Yin, Zin, alu_op, ZLowOut, ZHighOut, LOin, HIin, busy, done} !== 26'd0) begin
      fails++;
      $display("FAIL reset_outputs actual=%h required=0",
               {Rout, Yin, Zin, alu_op, ZLowOut, ZHighOut, LOin, HIin, busy, done});
    end
    repeat (2) tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_mul_basic();
    regs[3] = 32'd7; regs[5] = 32'd6;
    op = 1'b0; ra = 4'd3; rb = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (done !== 1'b1 || lo_reg !== 32'd42 || hi_reg !== 32'd0) begin
      fails++;
      $display("FAIL mul_result actual done=%b LO=%0d HI=%0d required done=1 LO=42 HI=0",
               done, lo_reg, hi_reg);
    end
    repeat (2) tick();
  endtask

  task automatic test_div_basic();
    regs[1] = 32'd100; regs[2] = 32'd7;
    op = 1'b1; ra = 4'd1; rb = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (35) tick();
    vectors++;
    if (done !== 1'b1 || lo_reg !== 32'd14 || hi_reg !== 32'd2) begin
      fails++;
      $display("FAIL div_result actual done=%b LO=%0d HI=%0d required done=1 LO=14 HI=2",
               done, lo_reg, hi_reg);
    end
    repeat (2) tick();
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int busy_low = 0;
    regs[1] = 32'd100; regs[2] = 32'd7; regs[9] = 32'd1000;
    op = 1'b1; ra = 4'd1; rb = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 35 && busy !== 1'b1) busy_low++;
      if (done === 1'b1) dones++;
      if (i == 3) begin start = 1'b1; op = 1'b0; ra = 4'd9; end
      if (i == 4) begin start = 1'b0; ra = 4'd0; end
      tick();
    end
    vectors++;
    if (dones != 1 || busy_low != 0 || lo_reg !== 32'd14 || hi_reg !== 32'd2) begin
      fails++;
      $display("FAIL ignore_start actual dones=%0d busy_low=%0d LO=%0d HI=%0d required 1 0 14 2",
               dones, busy_low, lo_reg, hi_reg);
    end
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    logic load_ok = 1'b0;
    op = 1'b0; ra = 4'd3; rb = 4'd5; start = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) begin
      if (done === 1'b1) begin
        if (first == 0) first = i; else second = i;
      end
      if (i == 1) begin ra = 4'd6; rb = 4'd3; end
      if (i == 6) begin
        load_ok = (Rout === 16'h0040) && (Yin === 1'b1);
        start = 1'b0;
      end
      tick();
    end
    vectors++;
    if (first != 5 || second != 10 || !load_ok) begin
      fails++;
      $display("FAIL back_to_back actual done@%0d,%0d loadY=%b required done@5,10 loadY=1",
               first, second, load_ok);
    end
  endtask

  task automatic test_clr_mid_exec();
    int d0;
    regs[1] = 32'd100; regs[2] = 32'd7; regs[3] = 32'd7; regs[5] = 32'd6;
    op = 1'b1; ra = 4'd1; rb = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 clr = 1'b1;
    #1;
    vectors++;
    if ({Rout, Yin, Zin, alu_op, ZLowOut, ZHighOut, LOin, HIin, busy, done} !== 26'd0) begin
      fails++;
      $display("FAIL clr_async actual=%h required=0",
               {Rout, Yin, Zin, alu_op, ZLowOut, ZHighOut, LOin, HIin, busy, done});
    end
    tick();
    clr = 1'b0;
    d0 = done_cnt;
    repeat (40) tick();
    vectors++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL clr_no_done actual=%0d required=0", done_cnt - d0);
    end
    op = 1'b0; ra = 4'd3; rb = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (done !== 1'b1 || lo_reg !== 32'd42) begin
      fails++;
      $display("FAIL clr_recover actual done=%b LO=%0d required done=1 LO=42", done, lo_reg);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    int a0, d0, cyc, n;
    a0 = acc_cnt; d0 = done_cnt; cyc = 0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom();
    while ((acc_cnt - a0) < 1000 && cyc < 60000) begin
      start = ($urandom_range(0, 3) != 0);
      op    = $urandom_range(0, 1);
      ra    = $urandom_range(0, 15);
      rb    = $urandom_range(0, 15);
      tick();
      cyc++;
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if ((acc_cnt - a0) < 1000 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_budget actual accepted=%0d pending=%0d required 1000 and 0",
               acc_cnt - a0, exp_q.size());
    end
    vectors++;
    if ((done_cnt - d0) != (acc_cnt - a0)) begin
      fails++;
      $display("FAIL random_done_count actual=%0d required=%0d", done_cnt - d0, acc_cnt - a0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    test_reset();
    test_mul_basic();
    test_div_basic();
    test_ignore_start();
    test_back_to_back();
    test_clr_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
